// File: rtl/kernel_mc.sv
// kernel_mc: KxK neighbourhood extractor over a multi-channel pixel stream, one line RAM written per row.
// Optional feature: define KERNEL_MC_ZERO_INVALID_EN to force kernel_datao to 0 whenever dvo is low.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 8
`endif
`ifndef DTYPE_FRAME_START
`define DTYPE_FRAME_START 8'h01
`endif
`ifndef DTYPE_FRAME_END
`define DTYPE_FRAME_END 8'h02
`endif
`ifndef DTYPE_ROW_START
`define DTYPE_ROW_START 8'h04
`endif
`ifndef DTYPE_ROW_END
`define DTYPE_ROW_END 8'h08
`endif
`ifndef DTYPE_HEADER_START
`define DTYPE_HEADER_START 8'h10
`endif
`ifndef DTYPE_HEADER
`define DTYPE_HEADER 8'h20
`endif
`ifndef DTYPE_PIXEL_MASK
`define DTYPE_PIXEL_MASK 8'h40
`endif
`ifndef Image_num_cols
`define Image_num_cols 6'd1
`endif
`ifndef Image_num_rows
`define Image_num_rows 6'd2
`endif

module kernel_mc #(
  parameter int KERNEL_SIZE    = 3,
  parameter int PIXEL_WIDTH    = 10,
  parameter int NUM_CHANNELS   = 1,
  parameter int DATA_WIDTH     = 16,
  parameter int MAX_COLS       = 1288,
  parameter int NUM_COLS_WIDTH = 11
) (
  input  logic                                                   clk,
  input  logic                                                   resetb,
  input  logic                                                   dvi,
  input  logic [`DTYPE_WIDTH-1:0]                                dtypei,
  input  logic [NUM_CHANNELS*PIXEL_WIDTH-1:0]                    datai,
  input  logic [DATA_WIDTH-1:0]                                  meta_datai,
  input  logic                                                   enable,
  output logic                                                   dvo,
  output logic [`DTYPE_WIDTH-1:0]                                dtypeo,
  output logic [DATA_WIDTH-1:0]                                  meta_datao,
  output logic [KERNEL_SIZE*KERNEL_SIZE*NUM_CHANNELS*PIXEL_WIDTH-1:0] kernel_datao,
  output logic                                                   row_len_err,
  output logic                                                   col_overflow
);
  localparam int K      = KERNEL_SIZE;
  localparam int BORDER = K - 1;
  localparam int NR     = K - 1;
  localparam int TW     = NUM_CHANNELS * PIXEL_WIDTH;
  localparam int SEL_W  = (NR > 1) ? $clog2(NR) : 1;
  localparam int SUM_W  = SEL_W + 1;
  localparam int ROW_W  = 12;
  localparam int CW     = NUM_COLS_WIDTH;

  logic [CW-1:0]           r_col_addr, r_row0_len;
  logic [ROW_W-1:0]        r_row_addr;
  logic [SEL_W-1:0]        r_wr_sel;
  logic [5:0]              r_header_addr;
  logic [K*K*TW-1:0]       r_taps;
  logic                    r_dvo, r_row_len_err, r_col_overflow;
  logic [`DTYPE_WIDTH-1:0] r_dtypeo;
  logic [DATA_WIDTH-1:0]   r_meta;

  logic                    w_fs, w_rs, w_re, w_pix, w_hs, w_hdr;
  logic                    w_valid_row, w_valid_col, w_col_full, w_ram_we, w_dvo;
  logic [CW-1:0]           w_rd_addr;
  logic [DATA_WIDTH-1:0]   w_meta;
  logic [K*K*TW-1:0]       w_taps_shift;
  logic [TW-1:0]           w_ram_rd [NR];
  logic [TW-1:0]           w_col_in [K];

  assign w_fs  = dtypei == `DTYPE_FRAME_START;
  assign w_rs  = dtypei == `DTYPE_ROW_START;
  assign w_re  = dtypei == `DTYPE_ROW_END;
  assign w_hs  = dtypei == `DTYPE_HEADER_START;
  assign w_hdr = dtypei == `DTYPE_HEADER;
  assign w_pix = (dtypei & `DTYPE_PIXEL_MASK) != '0;

  assign w_valid_row = r_row_addr >= ROW_W'(BORDER);
  assign w_valid_col = r_col_addr >= CW'(BORDER);
  assign w_col_full  = r_col_addr >= CW'(MAX_COLS);
  assign w_ram_we    = dvi && enable && !w_fs && !w_rs && !w_re && w_pix && !w_col_full;
  // Clamp keeps the read inside the RAM while an overlong row is being absorbed.
  assign w_rd_addr   = w_col_full ? CW'(MAX_COLS - 1) : r_col_addr;

  genvar gi;
  generate
    for (gi = 0; gi < NR; gi++) begin : g_ram
      logic [TW-1:0] r_mem [MAX_COLS];
      always_ff @(posedge clk)
        if (w_ram_we && r_wr_sel == SEL_W'(gi)) r_mem[w_rd_addr] <= datai;
      assign w_ram_rd[gi] = r_mem[w_rd_addr];
    end

    // RAM wr_sel still holds the oldest row until this beat's write lands, so tap row r reads wr_sel+r.
    for (gi = 0; gi < K; gi++) begin : g_row
      if (gi < NR) begin : g_hist
        logic [SUM_W-1:0] w_sum;
        logic [SEL_W-1:0] w_idx;
        assign w_sum = {1'b0, r_wr_sel} + SUM_W'(gi);
        assign w_idx = (w_sum >= SUM_W'(NR)) ? SEL_W'(w_sum - SUM_W'(NR)) : w_sum[SEL_W-1:0];
        assign w_col_in[gi] = w_ram_rd[w_idx];
      end else begin : g_cur
        assign w_col_in[gi] = datai;
      end
      assign w_taps_shift[gi*K*TW +: (K-1)*TW] = r_taps[gi*K*TW + TW +: (K-1)*TW];
      assign w_taps_shift[(gi*K+K-1)*TW +: TW] = w_col_in[gi];
    end
  endgenerate

  always_comb begin
    w_dvo = 1'b0;
    if (dvi) begin
      if (!enable || w_fs)  w_dvo = 1'b1;
      else if (w_rs || w_re) w_dvo = w_valid_row;
      else if (w_pix)        w_dvo = w_valid_row && w_valid_col;
      else                   w_dvo = 1'b1;
    end
    w_meta = meta_datai;
    if (enable && dvi && (r_header_addr == `Image_num_cols || r_header_addr == `Image_num_rows))
      w_meta = meta_datai - DATA_WIDTH'(BORDER);
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_dvo          <= 1'b0;
      r_dtypeo       <= '0;
      r_meta         <= '0;
      r_taps         <= '0;
      r_col_addr     <= '0;
      r_row_addr     <= '0;
      r_row0_len     <= '0;
      r_wr_sel       <= '0;
      r_header_addr  <= '0;
      r_row_len_err  <= 1'b0;
      r_col_overflow <= 1'b0;
    end else begin
      r_dvo    <= w_dvo;
      r_dtypeo <= dtypei;
      r_meta   <= w_meta;
      if (dvi && w_hs)       r_header_addr <= '0;
      else if (dvi && w_hdr) r_header_addr <= r_header_addr + 1'b1;
      if (!enable) begin
        r_row_addr <= '0;
        r_col_addr <= '0;
      end else if (dvi) begin
        if (w_fs) begin
          r_row_addr     <= '0;
          r_wr_sel       <= '0;
          r_row0_len     <= '0;
          r_row_len_err  <= 1'b0;
          r_col_overflow <= 1'b0;
        end else if (w_rs) begin
          r_col_addr <= '0;
        end else if (w_re) begin
          if (r_row_addr != '1) r_row_addr <= r_row_addr + 1'b1;
          r_wr_sel <= (r_wr_sel == SEL_W'(NR - 1)) ? '0 : r_wr_sel + 1'b1;
          if (r_row_addr == '0)              r_row0_len    <= r_col_addr;
          else if (r_col_addr != r_row0_len) r_row_len_err <= 1'b1;
        end else if (w_pix) begin
          r_taps <= w_taps_shift;
          if (w_col_full) r_col_overflow <= 1'b1;
          else            r_col_addr     <= r_col_addr + 1'b1;
        end
      end
    end
  end

  assign dvo          = r_dvo;
  assign dtypeo       = r_dtypeo;
  assign meta_datao   = r_meta;
  assign row_len_err  = r_row_len_err;
  assign col_overflow = r_col_overflow;
`ifdef KERNEL_MC_ZERO_INVALID_EN
  assign kernel_datao = r_dvo ? r_taps : '0;
`else
  assign kernel_datao = r_taps;
`endif
endmodule
